pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the 8-bit microprocessor and its wider derivatives.
- Generates the next fetch address every cycle from one of these sources:
  - sequential increment
  - absolute branch/jump
  - PC-relative branch
  - subroutine call/return, backed by an internal return-address stack (RAS)
- Sits between the control unit/decoder and instruction memory; pc_out drives the instruction-memory address directly.

Parameters:
- AW, 8, address/PC width in bits; all PC arithmetic is modulo 2^AW.
- RAS_DEPTH, 4, number of return-address stack entries (power of two, >= 2).
- RST_VEC, 0, PC value loaded on reset.
- TRAP_VEC, {AW{1'b1}}, PC loaded on a stack fault (used only with PC_TRAP_EN).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold PC and RAS unchanged this cycle
- br_en  in  1  take branch this cycle
- br_rel  in  1  1: target = pc_out + br_offset (signed); 0: target = br_target
- br_target  in  AW  absolute branch/call target
- br_offset  in  AW  two's-complement relative offset
- call  in  1  push return address, jump to br_target
- ret  in  1  pop return address into PC
- pc_out  out  AW  current PC (registered)
- pc_next  out  AW  combinational next-PC value (for prefetch)
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_ovf  out  1  sticky: call issued while full
- ras_unf  out  1  sticky: ret issued while empty

Behaviour:
- Reset:
  - pc_out = RST_VEC; RAS count = 0; ras_empty = 1; ras_full = 0; ras_ovf = 0; ras_unf = 0.
  - rst overrides stall and every other request.
- Selection priority, evaluated each clk when not in reset: stall > ret > call > br_en > increment.
  - stall: pc_out, RAS contents, count and flags are all held; pc_next = pc_out.
  - ret, RAS non-empty: pc_out <= top entry; count decrements.
  - ret, RAS empty: ras_unf <= 1; pc_out <= pc_out + 1 (no-op return).
  - call: push (pc_out + 1) mod 2^AW; pc_out <= br_target. br_rel is ignored for call.
  - call, RAS full: the oldest entry is overwritten (circular buffer); count stays RAS_DEPTH; ras_ovf <= 1.
  - br_en with br_rel = 1: pc_out <= pc_out + br_offset (signed add, truncated to AW bits; wraps both directions).
  - br_en with br_rel = 0: pc_out <= br_target.
  - No request: pc_out <= pc_out + 1; AW'max wraps to 0.
- Simultaneous requests:
  - call and ret together: ret wins and no push occurs.
  - br_en with call or ret: br_en is ignored.
- Latency: one cycle from request to the new pc_out; pc_next reflects the selection in the same cycle.
- RAS structure: top-of-stack pointer plus count.
  - ras_empty = (count == 0); ras_full = (count == RAS_DEPTH).
  - Push and pop never happen in the same cycle.
- Sticky flags clear only on rst.

Optional Feature:
- Macro PC_TRAP_EN.
- Defined:
  - A ret on an empty RAS loads pc_out <= TRAP_VEC instead of incrementing.
  - A call on a full RAS loads pc_out <= TRAP_VEC, with no push and no overwrite.
  - Sticky flags are still set in both cases.
- Undefined: wrap/no-op behaviour as described in Behaviour; TRAP_VEC is unused.

Decomposition:
- Shared package pc_pkg:
  - Next-PC select enum: PC_SEL_HOLD, PC_SEL_INC, PC_SEL_BR_ABS, PC_SEL_BR_REL, PC_SEL_CALL, PC_SEL_RET.
  - Default AW and RAS_DEPTH constants, shared with the decoder and instruction memory.
- Sub-module pc_ras (circular return-address stack):
  - Ports: clk, rst, push, pop, din, dout, empty, full, count.
  - Instantiated once inside pc_unit; pc_unit itself holds the select logic, PC register and sticky flags.

Test Plan:
- Reset and increment: rst held 2 cycles, then idle 5 cycles -> pc_out goes 0,1,2,3,4,5. With AW=8 from pc_out = 0xFF, idle -> 0x00.
- Relative branch: pc_out = 0x10, br_en = 1, br_rel = 1, br_offset = 0xFC (-4) -> pc_out = 0x0C. From pc_out = 0xFE with offset 0x05 -> 0x03.
- Call/return nesting: call to 0x40 at pc 0x05, call to 0x80 at pc 0x42, ret, ret -> pc_out sequence 0x40, 0x80, 0x43, 0x06; ras_empty = 1 at the end.
- Overflow (RAS_DEPTH = 4): 5 nested calls from pcs 0x00, 0x10, 0x20, 0x30, 0x40 -> ras_ovf = 1, ras_full = 1. Four rets return 0x41, 0x31, 0x21, 0x11; a fifth ret sets ras_unf = 1.
- Stall and priority: stall = 1 with br_en and call asserted -> pc_out and RAS count unchanged. Next cycle, call = 1 and ret = 1 on a non-empty RAS -> pop only, no push.
- Reset mid-operation: RAS holding 3 entries, assert rst during a call -> pc_out = RST_VEC, count 0, all flags 0. With PC_TRAP_EN, ret on empty -> pc_out = 0xFF.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared program-counter definitions: next-PC source select and default sizes.
// Also consumed by the decoder and instruction memory so address widths agree.
package pc_pkg;

    localparam int PC_AW        = 8;
    localparam int PC_RAS_DEPTH = 4;

    typedef enum logic [2:0] {
        PC_SEL_HOLD,
        PC_SEL_INC,
        PC_SEL_BR_ABS,
        PC_SEL_BR_REL,
        PC_SEL_CALL,
        PC_SEL_RET
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Latency: push/pop take effect at the next clk; dout is the current top, combinational.
// Backpressure: none; pop on empty is ignored, the caller must not push and pop together.
module pc_ras
    import pc_pkg::*;
#(
    parameter  int AW    = PC_AW,
    parameter  int DEPTH = PC_RAS_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [PW-1:0] top_q, top_d;
    logic [CW-1:0] count_q, count_d;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[top_q];

    // The slot just above the top is the oldest entry once the buffer is full,
    // so advancing the pointer and writing there gives overwrite-on-overflow for free.
    always_comb begin
        mem_d   = mem_q;
        top_d   = top_q;
        count_d = count_q;
        if (push) begin
            top_d        = top_q + 1'b1;
            mem_d[top_d] = din;
            if (!full) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop && !empty) begin
            top_d   = top_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter: increment, absolute/relative branch, call/return via pc_ras. PC_TRAP_EN: RAS faults jump to TRAP_VEC.
// Latency: one clk from request to pc_out; pc_next shows the selected value in the same cycle.
// Backpressure: stall freezes PC, RAS and sticky flags; rst overrides everything.
module pc_unit
    import pc_pkg::*;
#(
    parameter int            AW        = PC_AW,
    parameter int            RAS_DEPTH = PC_RAS_DEPTH,
    parameter logic [AW-1:0] RST_VEC   = '0,
    parameter logic [AW-1:0] TRAP_VEC  = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          br_en,
    input  logic          br_rel,
    input  logic [AW-1:0] br_target,
    input  logic [AW-1:0] br_offset,
    input  logic          call,
    input  logic          ret,
    output logic [AW-1:0] pc_out,
    output logic [AW-1:0] pc_next,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_ovf,
    output logic          ras_unf
);

    localparam int CW = $clog2(RAS_DEPTH) + 1;

`ifdef PC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    pc_sel_e       sel;
    logic          ret_fault, call_fault;
    logic [AW-1:0] pc_q, pc_d;
    logic          ras_ovf_q, ras_ovf_d;
    logic          ras_unf_q, ras_unf_d;
    logic          ras_push, ras_pop;
    logic [AW-1:0] ras_dout;
    logic          ras_empty_w, ras_full_w;
    logic [CW-1:0] ras_count;

    // Priority: stall > ret > call > branch > increment.
    always_comb begin
        sel        = PC_SEL_INC;
        ret_fault  = 1'b0;
        call_fault = 1'b0;
        if (stall) begin
            sel = PC_SEL_HOLD;
        end else if (ret) begin
            if (ras_empty_w) begin
                ret_fault = 1'b1;
            end else begin
                sel = PC_SEL_RET;
            end
        end else if (call) begin
            sel        = PC_SEL_CALL;
            call_fault = ras_full_w;
        end else if (br_en) begin
            sel = br_rel ? PC_SEL_BR_REL : PC_SEL_BR_ABS;
        end
    end

    always_comb begin
        case (sel)
            PC_SEL_HOLD:   pc_d = pc_q;
            PC_SEL_INC:    pc_d = pc_q + 1'b1;
            PC_SEL_BR_ABS: pc_d = br_target;
            PC_SEL_BR_REL: pc_d = pc_q + br_offset;
            PC_SEL_CALL:   pc_d = br_target;
            PC_SEL_RET:    pc_d = ras_dout;
            default:       pc_d = pc_q;
        endcase
        if (TRAP_EN && (ret_fault || call_fault)) begin
            pc_d = TRAP_VEC;
        end
        ras_ovf_d = ras_ovf_q | call_fault;
        ras_unf_d = ras_unf_q | ret_fault;
        if (rst) begin
            pc_d      = RST_VEC;
            ras_ovf_d = 1'b0;
            ras_unf_d = 1'b0;
        end
    end

    // A trapping call leaves the stack untouched rather than overwriting.
    assign ras_push = (sel == PC_SEL_CALL) && !(TRAP_EN && call_fault) && !rst;
    assign ras_pop  = (sel == PC_SEL_RET) && !rst;

    pc_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_q + 1'b1),
        .dout  (ras_dout),
        .empty (ras_empty_w),
        .full  (ras_full_w),
        .count (ras_count)
    );

    always_ff @(posedge clk) begin
        pc_q      <= pc_d;
        ras_ovf_q <= ras_ovf_d;
        ras_unf_q <= ras_unf_d;
    end

    assign pc_out    = pc_q;
    assign pc_next   = pc_d;
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CW'(RAS_DEPTH));
    assign ras_ovf   = ras_ovf_q;
    assign ras_unf   = ras_unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_pc_unit;

    localparam int            AW     = 8;
    localparam int            D      = 4;
    localparam logic [AW-1:0] RST_V  = 8'h00;
    localparam logic [AW-1:0] TRAP_V = 8'hFF;
`ifdef PC_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, stall, br_en, br_rel, call, ret;
    logic [AW-1:0] br_target, br_offset;
    logic [AW-1:0] pc_out, pc_next;
    logic          ras_empty, ras_full, ras_ovf, ras_unf;

    pc_unit #(
        .AW        (AW),
        .RAS_DEPTH (D),
        .RST_VEC   (RST_V),
        .TRAP_VEC  (TRAP_V)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_en     (br_en),
        .br_rel    (br_rel),
        .br_target (br_target),
        .br_offset (br_offset),
        .call      (call),
        .ret       (ret),
        .pc_out    (pc_out),
        .pc_next   (pc_next),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the stack is a queue, newest at the back.
    logic [AW-1:0] m_pc = '0;
    logic [AW-1:0] m_ras [$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    logic [AW-1:0] exp_next, obs_next;

    task automatic model_step();
        logic [AW-1:0] npc;
        npc = m_pc;
        if (rst) begin
            npc = RST_V;
            m_ras.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (stall) begin
            npc = m_pc;
        end else if (ret) begin
            if (m_ras.size() > 0) begin
                npc = m_ras.pop_back();
            end else begin
                m_unf = 1'b1;
                npc = TRAP ? TRAP_V : m_pc + 8'd1;
            end
        end else if (call) begin
            if (m_ras.size() == D) begin
                m_ovf = 1'b1;
                if (TRAP) begin
                    npc = TRAP_V;
                end else begin
                    void'(m_ras.pop_front());
                    m_ras.push_back(m_pc + 8'd1);
                    npc = br_target;
                end
            end else begin
                m_ras.push_back(m_pc + 8'd1);
                npc = br_target;
            end
        end else if (br_en) begin
            npc = br_rel ? m_pc + br_offset : br_target;
        end else begin
            npc = m_pc + 8'd1;
        end
        exp_next = npc;
        m_pc     = npc;
    endtask

    task automatic tick();
        #1;
        obs_next = pc_next;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rs, input bit st, input bit be, input bit rel,
                         input bit c, input bit r,
                         input logic [AW-1:0] tgt, input logic [AW-1:0] off);
        rst = rs; stall = st; br_en = be; br_rel = rel; call = c; ret = r;
        br_target = tgt; br_offset = off;
        tick();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        n_checks++; if (pc_out !== RST_V) begin n_fail++; $display("FAIL reset_pc got=%h want=%h", pc_out, RST_V); end
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b want=1", ras_empty); end
        n_checks++; if (ras_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b want=0", ras_full); end
        n_checks++; if ({ras_ovf, ras_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b%b want=00", ras_ovf, ras_unf); end
        for (int i = 1; i <= 5; i++) begin
            idle();
            n_checks++; if (pc_out !== 8'(i)) begin n_fail++; $display("FAIL inc_seq[%0d] got=%h want=%h", i, pc_out, 8'(i)); end
        end
    endtask

    task automatic test_wrap();
        drive(0, 0, 1, 0, 0, 0, 8'hFF, 8'h00);
        n_checks++; if (pc_out !== 8'hFF) begin n_fail++; $display("FAIL abs_ff got=%h want=ff", pc_out); end
        idle();
        n_checks++; if (pc_out !== 8'h00) begin n_fail++; $display("FAIL inc_wrap got=%h want=00", pc_out); end
    endtask

    task automatic test_rel_branch();
        drive(0, 0, 1, 0, 0, 0, 8'h10, 8'h00);
        drive(0, 0, 1, 1, 0, 0, 8'hAA, 8'hFC);
        n_checks++; if (obs_next !== 8'h0C) begin n_fail++; $display("FAIL rel_back_next got=%h want=0c", obs_next); end
        n_checks++; if (pc_out !== 8'h0C) begin n_fail++; $display("FAIL rel_back got=%h want=0c", pc_out); end
        drive(0, 0, 1, 0, 0, 0, 8'hFE, 8'h00);
        drive(0, 0, 1, 1, 0, 0, 8'h55, 8'h05);
        n_checks++; if (pc_out !== 8'h03) begin n_fail++; $display("FAIL rel_wrap got=%h want=03", pc_out); end
    endtask

    task automatic test_call_ret();
        drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 1, 0, 0, 0, 8'h05, 8'h00);
        drive(0, 0, 0, 0, 1, 0, 8'h40, 8'h00);
        n_checks++; if (pc_out !== 8'h40 || ras_empty !== 1'b0) begin n_fail++; $display("FAIL call1 got=%h/%b want=40/0", pc_out, ras_empty); end
        idle(); idle();
        drive(0, 0, 0, 0, 1, 0, 8'h80, 8'h00);
        n_checks++; if (pc_out !== 8'h80) begin n_fail++; $display("FAIL call2 got=%h want=80", pc_out); end
        drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        n_checks++; if (pc_out !== 8'h43) begin n_fail++; $display("FAIL ret1 got=%h want=43", pc_out); end
        drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        n_checks++; if (pc_out !== 8'h06) begin n_fail++; $display("FAIL ret2 got=%h want=06", pc_out); end
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL nest_empty got=%b want=1", ras_empty); end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] exp_r [5];
`ifdef PC_TRAP_EN
        exp_r = '{8'h31, 8'h21, 8'h11, 8'h01, 8'hFF};
`else
        exp_r = '{8'h41, 8'h31, 8'h21, 8'h11, 8'h12};
`endif
        drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 0, 0, 1, 0, 8'(k * 16), 8'h00);
        end
        n_checks++; if (ras_ovf !== 1'b1 || ras_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got=%b/%b want=1/1", ras_ovf, ras_full); end
        n_checks++; if (pc_out !== m_pc) begin n_fail++; $display("FAIL ovf_pc got=%h want=%h", pc_out, m_pc); end
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
            n_checks++; if (pc_out !== exp_r[k]) begin n_fail++; $display("FAIL ovf_ret[%0d] got=%h want=%h", k, pc_out, exp_r[k]); end
        end
        n_checks++; if (ras_unf !== 1'b1 || ras_ovf !== 1'b1) begin n_fail++; $display("FAIL unf_sticky got=%b/%b want=1/1", ras_unf, ras_ovf); end
    endtask

    task automatic test_stall_priority();
        drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 0, 1, 0, 8'h20, 8'h00);
        drive(0, 1, 1, 0, 1, 0, 8'h77, 8'h00);
        n_checks++; if (pc_out !== 8'h20 || obs_next !== 8'h20) begin n_fail++; $display("FAIL stall_hold got=%h/%h want=20/20", pc_out, obs_next); end
        n_checks++; if (ras_empty !== 1'b0 || ras_full !== 1'b0) begin n_fail++; $display("FAIL stall_ras got=%b/%b want=0/0", ras_empty, ras_full); end
        drive(0, 0, 0, 0, 1, 1, 8'h99, 8'h00);
        n_checks++; if (pc_out !== 8'h01 || ras_empty !== 1'b1) begin n_fail++; $display("FAIL ret_over_call got=%h/%b want=01/1", pc_out, ras_empty); end
        drive(0, 0, 1, 1, 1, 0, 8'h50, 8'h10);
        n_checks++; if (pc_out !== 8'h50) begin n_fail++; $display("FAIL call_over_br got=%h want=50", pc_out); end
        drive(0, 0, 1, 0, 0, 1, 8'h33, 8'h00);
        n_checks++; if (pc_out !== 8'h02) begin n_fail++; $display("FAIL ret_over_br got=%h want=02", pc_out); end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] exp_empty_ret;
`ifdef PC_TRAP_EN
        exp_empty_ret = 8'hFF;
`else
        exp_empty_ret = 8'h01;
`endif
        drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        drive(0, 0, 0, 0, 1, 0, 8'h10, 8'h00);
        drive(0, 0, 0, 0, 1, 0, 8'h20, 8'h00);
        drive(0, 0, 0, 0, 1, 0, 8'h30, 8'h00);
        n_checks++; if (ras_unf !== 1'b1 || ras_empty !== 1'b0) begin n_fail++; $display("FAIL pre_rst got=%b/%b want=1/0", ras_unf, ras_empty); end
        drive(1, 0, 0, 0, 1, 0, 8'h44, 8'h00);
        n_checks++; if (pc_out !== RST_V) begin n_fail++; $display("FAIL mid_rst_pc got=%h want=%h", pc_out, RST_V); end
        n_checks++; if ({ras_empty, ras_full, ras_ovf, ras_unf} !== 4'b1000) begin n_fail++; $display("FAIL mid_rst_flags got=%b%b%b%b want=1000", ras_empty, ras_full, ras_ovf, ras_unf); end
        drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        n_checks++; if (pc_out !== exp_empty_ret) begin n_fail++; $display("FAIL empty_ret got=%h want=%h", pc_out, exp_empty_ret); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom % 60) == 0, ($urandom % 6) == 0, ($urandom % 3) == 0,
                  ($urandom % 2) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
                  8'($urandom), 8'($urandom));
            n_checks++; if (obs_next !== exp_next) begin n_fail++; $display("FAIL rnd_next[%0d] got=%h want=%h", n, obs_next, exp_next); end
            n_checks++; if (pc_out !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got=%h want=%h", n, pc_out, m_pc); end
            n_checks++;
            if (ras_empty !== (m_ras.size() == 0) || ras_full !== (m_ras.size() == D)) begin
                n_fail++; $display("FAIL rnd_level[%0d] got=%b/%b want_size=%0d", n, ras_empty, ras_full, m_ras.size());
            end
            n_checks++;
            if (ras_ovf !== m_ovf || ras_unf !== m_unf) begin
                n_fail++; $display("FAIL rnd_flags[%0d] got=%b/%b want=%b/%b", n, ras_ovf, ras_unf, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br_en = 1'b0; br_rel = 1'b0; call = 1'b0; ret = 1'b0;
        br_target = '0; br_offset = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_wrap();
        test_rel_branch();
        test_call_ret();
        test_overflow();
        test_stall_priority();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
